// File: rtl/counter_mod_n_ud.sv
// counter_mod_n_ud: cascadable modulo-N up/down counter with wrap or saturate boundary mode
module counter_mod_n_ud #(
   parameter int WIDTH = 8,
   parameter int N     = 60,
   parameter int WRAP  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             at_max,
   output logic             at_min,
   output logic             wrapped
);
   localparam logic [WIDTH-1:0] MAX = WIDTH'(N - 1);
   localparam logic             W   = (WRAP != 0);
   logic [WIDTH-1:0] nxt;
   assign at_max = (count == MAX);
   assign at_min = (count == '0);
   assign tc     = en & ~clr & ~load & W & ((up & at_max) | (~up & at_min));
   always_comb begin
      nxt = clr  ? '0 :
            load ? ((load_val > MAX) ? MAX : load_val) :
            !en  ? count :
            up   ? (at_max ? (W ? '0 : count) : count + WIDTH'(1)) :
                   (at_min ? (W ? MAX : count) : count - WIDTH'(1));
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count   <= '0;
         wrapped <= 1'b0;
      end else begin
         count   <= nxt;
         wrapped <= tc;
      end
   end
endmodule

// File: tb/tb_counter_mod_n_ud.sv
// tb_counter_mod_n_ud: directed-vector bench for wrap, saturate, priority, cascade and async reset
module tb_counter_mod_n_ud;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   logic       en_a = 0, up_a = 0, clr_a = 0, load_a = 0;
   logic [7:0] lv_a = 0, cnt_a;
   logic       tc_a, max_a, min_a, wr_a;
   logic       en_s = 0, up_s = 0, clr_s = 0, load_s = 0;
   logic [7:0] lv_s = 0, cnt_s;
   logic       tc_s, max_s, min_s, wr_s;
   logic       en_c = 0, load_c = 0;
   logic [7:0] lv_sec = 0, lv_min = 0, lv_hr = 0, cnt_sec, cnt_min, cnt_hr;
   logic       tc_sec, tc_min, tc_hr, mx_sec, mx_min, mx_hr, mn_sec, mn_min, mn_hr, wr_sec, wr_min, wr_hr;

   always #5 clk = ~clk;

   counter_mod_n_ud #(.WIDTH(8), .N(60), .WRAP(1)) u_a (
      .clk(clk), .reset(reset), .en(en_a), .up(up_a), .clr(clr_a), .load(load_a), .load_val(lv_a),
      .count(cnt_a), .tc(tc_a), .at_max(max_a), .at_min(min_a), .wrapped(wr_a));
   counter_mod_n_ud #(.WIDTH(8), .N(60), .WRAP(0)) u_s (
      .clk(clk), .reset(reset), .en(en_s), .up(up_s), .clr(clr_s), .load(load_s), .load_val(lv_s),
      .count(cnt_s), .tc(tc_s), .at_max(max_s), .at_min(min_s), .wrapped(wr_s));
   counter_mod_n_ud #(.WIDTH(8), .N(60), .WRAP(1)) u_sec (
      .clk(clk), .reset(reset), .en(en_c), .up(1'b1), .clr(1'b0), .load(load_c), .load_val(lv_sec),
      .count(cnt_sec), .tc(tc_sec), .at_max(mx_sec), .at_min(mn_sec), .wrapped(wr_sec));
   counter_mod_n_ud #(.WIDTH(8), .N(60), .WRAP(1)) u_min (
      .clk(clk), .reset(reset), .en(tc_sec), .up(1'b1), .clr(1'b0), .load(load_c), .load_val(lv_min),
      .count(cnt_min), .tc(tc_min), .at_max(mx_min), .at_min(mn_min), .wrapped(wr_min));
   counter_mod_n_ud #(.WIDTH(8), .N(24), .WRAP(1)) u_hr (
      .clk(clk), .reset(reset), .en(tc_min), .up(1'b1), .clr(1'b0), .load(load_c), .load_val(lv_hr),
      .count(cnt_hr), .tc(tc_hr), .at_max(mx_hr), .at_min(mn_hr), .wrapped(wr_hr));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #3;
      chk("rst_cnt", 32'(cnt_a), 0);
      chk("rst_min", 32'(min_a), 1);
      chk("rst_max", 32'(max_a), 0);
      chk("rst_wr", 32'(wr_a), 0);
      en_a = 1; up_a = 0;
      #1 chk("rst_tc_down", 32'(tc_a), 1);
      en_a = 0;
      @(negedge clk) reset = 0;
      step();
      load_a = 1; lv_a = 58;
      step();
      chk("up_load58", 32'(cnt_a), 58);
      load_a = 0; en_a = 1; up_a = 1;
      #1 chk("up_tc58", 32'(tc_a), 0);
      step();
      chk("up_cnt59", 32'(cnt_a), 59);
      chk("up_tc59", 32'(tc_a), 1);
      chk("up_max59", 32'(max_a), 1);
      step();
      chk("up_cnt0", 32'(cnt_a), 0);
      chk("up_wr0", 32'(wr_a), 1);
      chk("up_tc0", 32'(tc_a), 0);
      step();
      chk("up_cnt1", 32'(cnt_a), 1);
      chk("up_wr1", 32'(wr_a), 0);
      up_a = 0;
      step();
      chk("dn_cnt0", 32'(cnt_a), 0);
      chk("dn_tc0", 32'(tc_a), 1);
      step();
      chk("dn_cnt59", 32'(cnt_a), 59);
      chk("dn_wr59", 32'(wr_a), 1);
      chk("dn_tc59", 32'(tc_a), 0);
      step();
      chk("dn_cnt58", 32'(cnt_a), 58);
      chk("dn_wr58", 32'(wr_a), 0);
      clr_a = 1; load_a = 1; en_a = 1; lv_a = 5;
      step();
      chk("pri_clr", 32'(cnt_a), 0);
      clr_a = 0; lv_a = 200; en_a = 0;
      step();
      chk("clamp200", 32'(cnt_a), 59);
      lv_a = 17; en_a = 1; up_a = 1;
      #1 chk("load_tc_mask", 32'(tc_a), 0);
      step();
      chk("load17", 32'(cnt_a), 17);
      chk("load_wr", 32'(wr_a), 0);
      en_a = 0; lv_a = 42;
      step();
      chk("load42", 32'(cnt_a), 42);
      load_a = 0; en_a = 1; up_a = 1;
      #2 reset = 1;
      #1 chk("async_cnt", 32'(cnt_a), 0);
      chk("async_min", 32'(min_a), 1);
      @(negedge clk) reset = 0;
      step();
      chk("post_rst_cnt", 32'(cnt_a), 1);
      chk("post_rst_wr", 32'(wr_a), 0);
      en_a = 0; up_a = 0;
      load_s = 1; lv_s = 59;
      step();
      load_s = 0; en_s = 1; up_s = 1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("sat_cnt59", 32'(cnt_s), 59);
         chk("sat_tc", 32'(tc_s), 0);
         chk("sat_wr", 32'(wr_s), 0);
      end
      up_s = 0;
      step();
      chk("sat_dn58", 32'(cnt_s), 58);
      load_s = 1; lv_s = 0;
      step();
      load_s = 0;
      step();
      chk("sat_lo0", 32'(cnt_s), 0);
      chk("sat_lo_tc", 32'(tc_s), 0);
      en_s = 0;
      load_c = 1; lv_sec = 59; lv_min = 59; lv_hr = 23;
      step();
      load_c = 0; en_c = 1;
      #1;
      chk("cas_tc_sec", 32'(tc_sec), 1);
      chk("cas_tc_min", 32'(tc_min), 1);
      chk("cas_tc_hr", 32'(tc_hr), 1);
      step();
      chk("cas_hms", {8'd0, cnt_hr, cnt_min, cnt_sec}, 0);
      chk("cas_wr", {29'd0, wr_hr, wr_min, wr_sec}, 7);
      step();
      chk("cas_hms2", {8'd0, cnt_hr, cnt_min, cnt_sec}, 1);
      chk("cas_wr2", {29'd0, wr_hr, wr_min, wr_sec}, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
